// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared definitions for the data-memory load/store unit:
//               access-size encodings, FSM state encoding, data width.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int DATA_W = 32;

    // Access size encodings as presented on req_size (2'b11 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Load/store unit FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_unit
// Description : Purely combinational byte-lane logic (little-endian lanes).
//               merge   : replaces the addressed byte/half of merge_word_i
//                         with right-aligned wdata_i; word size passes wdata_i.
//               extract : shifts the addressed byte/half of load_word_i down
//                         to bit 0 and sign- or zero-extends it.
// Ports       : merge_word_i  captured memory word for read-modify-write
//               load_word_i   memory word being loaded
//               wdata_i       right-aligned store data
//               size_i        access size (dm_pkg SZ_*)
//               lane_i        byte address bits [1:0]
//               signed_i      1 = sign-extend loads
//               merged_o      store word to write back
//               rdata_o       extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [DATA_W-1:0] merge_word_i,
    input  logic [DATA_W-1:0] load_word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        lane_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] merged_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Selected lane shifted to bit 0; half selection uses lane_i[1] only
    // because an odd half address never reaches this unit (error path).
    assign w_shifted = load_word_i >> {lane_i, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    always_comb begin
        merged_o = merge_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

    always_comb begin
        rdata_o = load_word_i;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: rdata_o = {{16{signed_i & w_half[15]}}, w_half};
            default: rdata_o = load_word_i;
        endcase
    end

endmodule : dm_lane_unit
`default_nettype wire

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dm_lsu
// Description : Initiator-side load/store unit for a word-addressed data
//               memory with combinational read and posedge write. Sub-word
//               stores use read-modify-write; loads are extended.
// Ports       : clk, rst (async, active-high)
//               req/req_we/req_size/req_signed/req_addr/req_wdata  CPU request
//               req_ready                                          accept when high
//               resp_valid/resp_rdata/resp_err                     completion
//               mem_addr/mem_din/mem_we/mem_dout                   memory side
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lsu
    import dm_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    state_t              state_q, state_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                w_accept;
    logic                w_err;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_extract;
    logic                w_unused_addr;

    // Byte-address bits above the memory are dropped so accesses wrap.
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

    assign w_accept = req && (state_q == IDLE);

    assign w_err = (req_size == 2'b11)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    dm_lane_unit u_lane (
        .merge_word_i (word_q),
        .load_word_i  (mem_dout),
        .wdata_i      (wdata_q),
        .size_i       (size_q),
        .lane_i       (addr_q[1:0]),
        .signed_i     (signed_q),
        .merged_o     (w_merged),
        .rdata_o      (w_extract)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (w_err) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else if (!req_we) begin
                        state_d = RD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d = WR;
                end else begin
                    // Load result registered on entry to RESP so it is held
                    // until the next response.
                    state_d = RESP;
                    rdata_d = w_extract;
                end
            end
            WR: begin
                state_d = RESP;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (w_accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr[ADDR_W+1:0];
                wdata_q  <= req_wdata;
                err_q    <= w_err;
            end
            if (state_q == RD) begin
                word_q <= mem_dout;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = rdata_q;

    // Write enable decodes straight from the state register, so an async
    // reset drops it immediately and no partial write can occur.
    assign mem_we   = (state_q == WR);
    assign mem_addr = addr_q[ADDR_W+1:2];
    assign mem_din  = (state_q == WR) ? w_merged : '0;

endmodule : dm_lsu
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_lsu
// Description : Self-checking bench for dm_lsu with a behavioural word memory
//               (async read, posedge write). Directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_lsu;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              req;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks;
    int failures;

    dm_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    // Issues one request and watches it to completion. lat is the cycle
    // (1 = first cycle after acceptance) in which resp_valid was seen, -1 if never.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int we_cnt, output int we_cyc,
                          output logic [ADDR_W-1:0] we_addr);
        lat = -1; err = 1'bx; rd = 'x; we_cnt = 0; we_cyc = -1; we_addr = '0;
        @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (mem_we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc  = c;
                    we_addr = mem_addr;
                end
            end
            if (resp_valid) begin
                lat = c;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl ready/valid/err/we got %b want 1000",
                     {req_ready, resp_valid, resp_err, mem_we});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got %h want 0", resp_rdata);
        end
        checks++;
        if (mem_addr !== '0 || mem_din !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem addr=%0d din=%h want 0/0", mem_addr, mem_din);
        end
    endtask

    task automatic test_load();
        int lat, wc, wy; logic e; logic [31:0] rd; logic [ADDR_W-1:0] wa;
        mem[3] = 32'h11223344;
        mem[5] = 32'h80FF0000;
        do_req(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h00000011 || wc !== 0) begin
            failures++;
            $display("FAIL ld_byte_0F lat=%0d err=%b rdata=%h we=%0d want 2/0/00000011/0",
                     lat, e, rd, wc);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || rd !== 32'h00000022) begin
            failures++;
            $display("FAIL ld_byte_0E lat=%0d rdata=%h want 2/00000022", lat, rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || rd !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL ld_byte_signed lat=%0d rdata=%h want 2/FFFFFFFF", lat, rd);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (rd !== 32'h000000FF) begin
            failures++; $display("FAIL ld_byte_unsigned rdata=%h want 000000FF", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || rd !== 32'hFFFF80FF) begin
            failures++;
            $display("FAIL ld_half_signed lat=%0d rdata=%h want 2/FFFF80FF", lat, rd);
        end
        do_req(1'b0, 2'b10, 1'b1, 32'h14, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h80FF0000) begin
            failures++;
            $display("FAIL ld_word lat=%0d err=%b rdata=%h want 2/0/80FF0000", lat, e, rd);
        end
    endtask

    task automatic test_store_sub();
        int lat, wc, wy; logic e; logic [31:0] rd; logic [ADDR_W-1:0] wa;
        mem[3] = 32'h11223344;
        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'h0 || wc !== 1 || wy !== 2 || wa !== 5'd3) begin
            failures++;
            $display("FAIL st_half lat=%0d err=%b rdata=%h we_cnt=%0d we_cyc=%0d addr=%0d want 3/0/0/1/2/3",
                     lat, e, rd, wc, wy, wa);
        end
        checks++;
        if (mem[3] !== 32'hBEEF3344) begin
            failures++; $display("FAIL st_half_mem got %h want BEEF3344", mem[3]);
        end
        do_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h123456AA, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 3 || wc !== 1 || mem[3] !== 32'hBEEFAA44) begin
            failures++;
            $display("FAIL st_byte lat=%0d we_cnt=%0d mem=%h want 3/1/BEEFAA44", lat, wc, mem[3]);
        end
    endtask

    task automatic test_store_word_wrap();
        int lat, wc, wy; logic e; logic [31:0] rd; logic [ADDR_W-1:0] wa;
        mem[31] = 32'h0; mem[0] = 32'h0;
        do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || wc !== 1 || wy !== 1 || wa !== 5'd31 || mem[31] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL st_word lat=%0d we_cnt=%0d we_cyc=%0d addr=%0d mem=%h want 2/1/1/31/DEADBEEF",
                     lat, wc, wy, wa, mem[31]);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 2 || wa !== 5'd0 || mem[0] !== 32'h12345678 || mem[31] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL st_wrap lat=%0d addr=%0d mem0=%h mem31=%h want 2/0/12345678/DEADBEEF",
                     lat, wa, mem[0], mem[31]);
        end
    endtask

    task automatic test_errors();
        int lat, wc, wy; logic e; logic [31:0] rd; logic [ADDR_W-1:0] wa;
        mem[1] = 32'hA5A5A5A5;
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            failures++;
            $display("FAIL err_word lat=%0d err=%b rdata=%h we=%0d want 1/1/0/0", lat, e, rd, wc);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            failures++;
            $display("FAIL err_half lat=%0d err=%b rdata=%h we=%0d want 1/1/0/0", lat, e, rd, wc);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, lat, e, rd, wc, wy, wa);
        checks++;
        if (lat !== 1 || e !== 1'b1 || wc !== 0 || mem[1] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL err_size lat=%0d err=%b we=%0d mem=%h want 1/1/0/A5A5A5A5",
                     lat, e, wc, mem[1]);
        end
    endtask

    task automatic test_async_reset();
        int resp_seen;
        mem[2] = 32'hCAFEF00D;
        resp_seen = 0;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h00000055;
        @(posedge clk);          // accept -> RD
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);          // now in WR
        checks++;
        if (mem_we !== 1'b1) begin
            failures++; $display("FAIL rst_pre_we got %b want 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_async we=%b ready=%b want 0/1", mem_we, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checks++;
        if (resp_seen !== 0 || req_ready !== 1'b1 || mem[2] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_after resp=%0d ready=%b mem=%h want 0/1/CAFEF00D",
                     resp_seen, req_ready, mem[2]);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, resps;
        logic [31:0] last_rd;
        accepts = 0; resps = 0; last_rd = '0;
        mem[4] = 32'h9ABC0102;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_size = 2'b01; req_signed = 1'b1;
        req_addr = 32'h12; req_wdata = 32'h0;
        for (int c = 0; c < 9; c++) begin
            if (req && req_ready) accepts++;
            if (resp_valid) begin
                resps++;
                last_rd = resp_rdata;
            end
            @(negedge clk);
        end
        req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid) resps++;
            @(negedge clk);
        end
        checks++;
        if (accepts !== 3 || resps !== 3) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d resps=%0d want 3/3", accepts, resps);
        end
        checks++;
        if (last_rd !== 32'hFFFF9ABC) begin
            failures++; $display("FAIL b2b_rdata got %h want FFFF9ABC", last_rd);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
        test_reset();
        test_load();
        test_store_sub();
        test_store_word_wrap();
        test_errors();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule : tb_dm_lsu
`default_nettype wire
